// File: rtl/regfile_pkg.sv
// Shared definitions for the scoreboarded register file: FSM encoding and
// default parameter values.
package regfile_pkg;

    typedef enum logic {
        ST_CLR = 1'b0,
        ST_RUN = 1'b1
    } rf_state_e;

    localparam int XLEN_DEF     = 32;
    localparam int NREG_DEF     = 32;
    localparam int NRD_DEF      = 2;
    localparam int ZERO_REG_DEF = 1;

endpackage

// File: rtl/rf_read_port.sv
// One combinational read port: write bypass mux plus ready (not pending) logic.
// Outputs are forced to zero while the register file is not running.
module rf_read_port
    import regfile_pkg::*;
#(
    parameter int XLEN     = XLEN_DEF,
    parameter int AW       = 5,
    parameter int ZERO_REG = ZERO_REG_DEF
) (
    input  logic [AW-1:0]   raddr,
    input  logic [XLEN-1:0] reg_data,
    input  logic            reg_pend,
    input  logic            run,
    input  logic            wenable,
    input  logic [AW-1:0]   waddr,
    input  logic [XLEN-1:0] wdata,
    output logic [XLEN-1:0] rdata,
    output logic            rready
);

    logic is_zero;
    logic hit;

    assign is_zero = (ZERO_REG != 0) && (raddr == '0);
    assign hit     = wenable && (waddr == raddr);

    // Register 0 is hard-wired (no bypass); otherwise an in-flight write wins.
    always_comb begin
        rdata  = '0;
        rready = 1'b0;
        if (run) begin
            if (is_zero) begin
                rdata  = '0;
                rready = 1'b1;
            end else if (hit) begin
                rdata  = wdata;
                rready = 1'b1;
            end else begin
                rdata  = reg_data;
                rready = !reg_pend;
            end
        end
    end

endmodule

// File: rtl/regfile_sb.sv
// Register file with a pending-producer scoreboard and a post-reset clear
// sequence that zeroes every register before normal operation.
//
//   state  | meaning
//   ST_CLR | zeroing register[idx] each cycle; writes/reserves ignored, outputs zero
//   ST_RUN | normal read/write/reserve operation
module regfile_sb
    import regfile_pkg::*;
#(
    parameter int XLEN     = XLEN_DEF,
    parameter int NREG     = NREG_DEF,
    parameter int NRD      = NRD_DEF,
    parameter int ZERO_REG = ZERO_REG_DEF,
    parameter int AW       = $clog2(NREG)
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [NRD*AW-1:0]   RFraddr,
    output logic [NRD*XLEN-1:0] RFrdata,
    output logic [NRD-1:0]      RFrready,
    input  logic                RFwenable,
    input  logic [AW-1:0]       RFwaddr,
    input  logic [XLEN-1:0]     RFwdata,
    input  logic                RFreserve,
    input  logic [AW-1:0]       RFreserve_addr,
    output logic                RFbusy,
    output logic [AW:0]         RFpending_cnt
);

    localparam int CW = AW + 1;

    rf_state_e        state, state_nx;
    logic [AW-1:0]    idx, idx_nx;
    logic             run_en;

    logic [XLEN-1:0]  mem [NREG];
    logic [NREG-1:0]  pending;
    logic [CW-1:0]    pend_cnt;

    logic             wr_ok;
    logic             rs_ok;
    logic             cnt_inc;
    logic             cnt_dec;

    // State and clear-index register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= ST_CLR;
            idx   <= '0;
        end else begin
            state <= state_nx;
            idx   <= idx_nx;
        end
    end

    // Next state; busy/run are also qualified by rst_n so reset shows busy at once.
    always_comb begin
        state_nx = state;
        idx_nx   = idx;
        RFbusy   = !rst_n;
        run_en   = 1'b0;
        case (state)
            ST_CLR: begin
                RFbusy = 1'b1;
                idx_nx = idx + 1'b1;
                if (idx == AW'(NREG - 1)) begin
                    state_nx = ST_RUN;
                    idx_nx   = '0;
                end
            end
            ST_RUN: begin
                run_en = rst_n;
            end
            default: begin
                state_nx = ST_CLR;
                idx_nx   = '0;
            end
        endcase
    end

    assign wr_ok = run_en && RFwenable
                   && !((ZERO_REG != 0) && (RFwaddr == '0));
    assign rs_ok = run_en && RFreserve
                   && !((ZERO_REG != 0) && (RFreserve_addr == '0));

    // A write that is re-reserved in the same cycle leaves the bit set, so no decrement.
    assign cnt_inc = rs_ok && !pending[RFreserve_addr];
    assign cnt_dec = wr_ok && pending[RFwaddr]
                     && !(rs_ok && (RFreserve_addr == RFwaddr));

    // Register array: zeroed one entry per cycle during clear, then written normally.
    always_ff @(posedge clk) begin
        if (rst_n) begin
            if (state == ST_CLR) begin
                mem[idx] <= '0;
            end else if (wr_ok) begin
                mem[RFwaddr] <= RFwdata;
            end
        end
    end

    // Pending bitmap and its population count; reserve is applied after the write clear.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pending  <= '0;
            pend_cnt <= '0;
        end else begin
            if (wr_ok) begin
                pending[RFwaddr] <= 1'b0;
            end
            if (rs_ok) begin
                pending[RFreserve_addr] <= 1'b1;
            end
            pend_cnt <= pend_cnt + CW'(cnt_inc) - CW'(cnt_dec);
        end
    end

    assign RFpending_cnt = pend_cnt;

    for (genvar k = 0; k < NRD; k++) begin : g_rd
        logic [AW-1:0] ra;
        assign ra = RFraddr[k*AW +: AW];

        rf_read_port #(
            .XLEN     (XLEN),
            .AW       (AW),
            .ZERO_REG (ZERO_REG)
        ) u_rd (
            .raddr    (ra),
            .reg_data (mem[ra]),
            .reg_pend (pending[ra]),
            .run      (run_en),
            .wenable  (RFwenable),
            .waddr    (RFwaddr),
            .wdata    (RFwdata),
            .rdata    (RFrdata[k*XLEN +: XLEN]),
            .rready   (RFrready[k])
        );
    end

endmodule

// File: tb/tb_regfile_sb.sv
// Randomized and directed bench for regfile_sb against an array-based model.
module tb_regfile_sb;

    localparam int XLEN = 32;
    localparam int NREG = 32;
    localparam int NRD  = 2;
    localparam int AW   = 5;

    logic                clk = 1'b0;
    logic                rst_n;
    logic [NRD*AW-1:0]   RFraddr;
    logic [NRD*XLEN-1:0] RFrdata;
    logic [NRD-1:0]      RFrready;
    logic                RFwenable;
    logic [AW-1:0]       RFwaddr;
    logic [XLEN-1:0]     RFwdata;
    logic                RFreserve;
    logic [AW-1:0]       RFreserve_addr;
    logic                RFbusy;
    logic [AW:0]         RFpending_cnt;

    always #5 clk = ~clk;

    regfile_sb #(
        .XLEN     (XLEN),
        .NREG     (NREG),
        .NRD      (NRD),
        .ZERO_REG (1)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .RFraddr        (RFraddr),
        .RFrdata        (RFrdata),
        .RFrready       (RFrready),
        .RFwenable      (RFwenable),
        .RFwaddr        (RFwaddr),
        .RFwdata        (RFwdata),
        .RFreserve      (RFreserve),
        .RFreserve_addr (RFreserve_addr),
        .RFbusy         (RFbusy),
        .RFpending_cnt  (RFpending_cnt)
    );

    int n_tests = 0;
    int n_fail  = 0;
    int busy_seen;

    logic [XLEN-1:0] m_reg [NREG];
    bit              m_pend [NREG];
    int              m_clr = NREG;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic idle_inputs();
        RFwenable      = 1'b0;
        RFwaddr        = '0;
        RFwdata        = '0;
        RFreserve      = 1'b0;
        RFreserve_addr = '0;
    endtask

    task automatic set_raddr(input int a0, input int a1);
        RFraddr[0 +: AW]  = AW'(a0);
        RFraddr[AW +: AW] = AW'(a1);
    endtask

    // Check all outputs against the model, then advance one clock and update the model.
    task automatic cycle();
        logic [AW-1:0]   a;
        logic [XLEN-1:0] ed;
        logic            er;
        int              pc;
        bit              busy_m;
        #1;
        busy_m = !rst_n || (m_clr > 0);
        chk("busy", 64'(RFbusy), 64'(busy_m));
        if (RFbusy) busy_seen++;
        if (rst_n) begin
            pc = 0;
            for (int i = 0; i < NREG; i++) pc += int'(m_pend[i]);
            chk("pending_cnt", 64'(RFpending_cnt), 64'(pc));
        end
        for (int k = 0; k < NRD; k++) begin
            a = RFraddr[k*AW +: AW];
            if (busy_m) begin
                ed = '0; er = 1'b0;
            end else if (a == 0) begin
                ed = '0; er = 1'b1;
            end else if (RFwenable && RFwaddr == a) begin
                ed = RFwdata; er = 1'b1;
            end else begin
                ed = m_reg[a]; er = !m_pend[a];
            end
            chk($sformatf("rdata%0d", k), 64'(RFrdata[k*XLEN +: XLEN]), 64'(ed));
            chk($sformatf("rready%0d", k), 64'(RFrready[k]), 64'(er));
        end
        @(posedge clk);
        if (!rst_n) begin
            m_clr = NREG;
            for (int i = 0; i < NREG; i++) begin
                m_reg[i]  = '0;
                m_pend[i] = 1'b0;
            end
        end else if (m_clr > 0) begin
            m_clr--;
        end else begin
            if (RFwenable && RFwaddr != 0) begin
                m_reg[RFwaddr]  = RFwdata;
                m_pend[RFwaddr] = 1'b0;
            end
            if (RFreserve && RFreserve_addr != 0) m_pend[RFreserve_addr] = 1'b1;
        end
        @(negedge clk);
    endtask

    initial begin
        rst_n = 1'b0;
        idle_inputs();
        set_raddr(0, 0);
        for (int i = 0; i < NREG; i++) begin
            m_reg[i]  = '0;
            m_pend[i] = 1'b0;
        end
        @(negedge clk);

        // Reset for 3 cycles, then count busy cycles through the clear.
        repeat (3) cycle();
        rst_n = 1'b1;
        busy_seen = 0;
        repeat (40) cycle();
        chk("clr_len", 64'(busy_seen), 64'd32);
        for (int i = 0; i < NREG; i += 2) begin
            set_raddr(i, i + 1);
            cycle();
        end

        // Bypass on reg 5.
        set_raddr(5, 1);
        RFwenable = 1'b1; RFwaddr = 5; RFwdata = 32'hDEADBEEF;
        #1 chk("bypass_same", 64'(RFrdata[0 +: XLEN]), 64'h0DEADBEEF);
        cycle();
        idle_inputs();
        #1 chk("bypass_next", 64'(RFrdata[0 +: XLEN]), 64'h0DEADBEEF);
        cycle();

        // Reserve reg 7, then write it.
        set_raddr(0, 7);
        RFreserve = 1'b1; RFreserve_addr = 7;
        cycle();
        idle_inputs();
        #1 chk("rsv7_ready", 64'(RFrready[1]), 64'd0);
        chk("rsv7_cnt", 64'(RFpending_cnt), 64'd1);
        cycle();
        RFwenable = 1'b1; RFwaddr = 7; RFwdata = 32'h12;
        #1 chk("wr7_ready", 64'(RFrready[1]), 64'd1);
        cycle();
        idle_inputs();
        #1 chk("wr7_cnt", 64'(RFpending_cnt), 64'd0);
        cycle();

        // Write + reserve reg 9 together, then reserve 3 while writing pending 9.
        set_raddr(9, 3);
        RFwenable = 1'b1; RFwaddr = 9; RFwdata = 32'hA5A5_0009;
        RFreserve = 1'b1; RFreserve_addr = 9;
        cycle();
        idle_inputs();
        #1 chk("wr_rs9_data", 64'(RFrdata[0 +: XLEN]), 64'hA5A5_0009);
        chk("wr_rs9_ready", 64'(RFrready[0]), 64'd0);
        chk("wr_rs9_cnt", 64'(RFpending_cnt), 64'd1);
        cycle();
        RFwenable = 1'b1; RFwaddr = 9; RFwdata = 32'h0000_0099;
        RFreserve = 1'b1; RFreserve_addr = 3;
        cycle();
        idle_inputs();
        #1 chk("rs3_wr9_cnt", 64'(RFpending_cnt), 64'd1);
        cycle();

        // Zero register write and reserve are dropped.
        set_raddr(0, 3);
        RFwenable = 1'b1; RFwaddr = 0; RFwdata = 32'hFFFFFFFF;
        RFreserve = 1'b1; RFreserve_addr = 0;
        #1 chk("r0_same", 64'(RFrdata[0 +: XLEN]), 64'd0);
        cycle();
        idle_inputs();
        #1 chk("r0_data", 64'(RFrdata[0 +: XLEN]), 64'd0);
        chk("r0_ready", 64'(RFrready[0]), 64'd1);
        chk("r0_cnt", 64'(RFpending_cnt), 64'd1);
        cycle();

        // Randomized traffic with occasional resets.
        for (int n = 0; n < 2000; n++) begin
            rst_n          = ($urandom_range(0, 299) != 0);
            RFwenable      = ($urandom_range(0, 1) == 1);
            RFwaddr        = AW'($urandom_range(0, NREG - 1));
            RFwdata        = $urandom;
            RFreserve      = ($urandom_range(0, 9) < 4);
            RFreserve_addr = AW'($urandom_range(0, NREG - 1));
            set_raddr($urandom_range(0, NREG - 1),
                      ($urandom_range(0, 3) == 0) ? int'(RFwaddr) : $urandom_range(0, NREG - 1));
            cycle();
        end
        rst_n = 1'b1;
        idle_inputs();
        while (m_clr > 0) cycle();

        // Reset at clear index 20, with a write issued during the restarted clear.
        rst_n = 1'b0;
        cycle();
        rst_n = 1'b1;
        repeat (20) cycle();
        rst_n = 1'b0;
        cycle();
        rst_n = 1'b1;
        busy_seen = 0;
        RFwenable = 1'b1; RFwaddr = 4; RFwdata = 32'h4444_4444;
        cycle();
        idle_inputs();
        repeat (36) cycle();
        chk("clr_restart_len", 64'(busy_seen), 64'd32);
        set_raddr(4, 5);
        #1 chk("clr_lockout", 64'(RFrdata[0 +: XLEN]), 64'd0);
        chk("clr_lockout_rdy", 64'(RFrready[0]), 64'd1);
        cycle();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not finish, tests %0d failed %0d", n_tests, n_fail);
        $fatal(1, "timeout");
    end

endmodule
